// File: rtl/execute_cycle.sv
// Execute stage of the RV32I pipeline: operand forwarding, ALU, branch decision and the E/M register.
// Optional macro EXEC_BRANCH_EXT_EN adds the full Funct3E-selected branch condition set.
module execute_cycle #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            ALUSrcE,
    input  logic            MemWriteE,
    input  logic            ResultSrcE,
    input  logic            BranchE,
    input  logic [2:0]      ALUControlE,
    input  logic [2:0]      Funct3E,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [4:0]      RD_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [XLEN-1:0] ResultW,
    input  logic [1:0]      ForwardA_E,
    input  logic [1:0]      ForwardB_E,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            ResultSrcM,
    output logic [4:0]      RD_M,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] ALU_ResultM
);

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            branch_cond;

    // Forwarding muxes; select 11 falls back to register data.
    always_comb begin
        fwd_a = RD1_E;
        case (ForwardA_E)
            2'b01:   fwd_a = ResultW;
            2'b10:   fwd_a = ALU_ResultM;
            default: fwd_a = RD1_E;
        endcase
        fwd_b = RD2_E;
        case (ForwardB_E)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALU_ResultM;
            default: fwd_b = RD2_E;
        endcase
    end

    assign src_a = fwd_a;
    assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

    always_comb begin
        alu_result = '0;
        case (ALUControlE)
            ALU_ADD:  alu_result = src_a + src_b;
            ALU_SUB:  alu_result = src_a - src_b;
            ALU_AND:  alu_result = src_a & src_b;
            ALU_OR:   alu_result = src_a | src_b;
            ALU_XOR:  alu_result = src_a ^ src_b;
            ALU_SLT:  alu_result = XLEN'($signed(src_a) < $signed(src_b));
            ALU_SLTU: alu_result = XLEN'(src_a < src_b);
            default:  alu_result = '0;
        endcase
    end

    assign PCTargetE = PCE + Imm_Ext_E;

`ifdef EXEC_BRANCH_EXT_EN
    // Condition evaluated on the forwarded operands, independent of the ALU op.
    always_comb begin
        branch_cond = 1'b0;
        case (Funct3E)
            3'b000:  branch_cond = (fwd_a == fwd_b);
            3'b001:  branch_cond = (fwd_a != fwd_b);
            3'b100:  branch_cond = ($signed(fwd_a) <  $signed(fwd_b));
            3'b101:  branch_cond = ($signed(fwd_a) >= $signed(fwd_b));
            3'b110:  branch_cond = (fwd_a <  fwd_b);
            3'b111:  branch_cond = (fwd_a >= fwd_b);
            default: branch_cond = 1'b0;
        endcase
    end
`else
    logic unused_funct3;
    assign unused_funct3 = ^Funct3E;
    assign branch_cond   = (alu_result == '0);
`endif

    assign PCSrcE = BranchE & branch_cond;

    // E/M pipeline register, loads every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
            RD_M        <= '0;
            PCPlus4M    <= '0;
            WriteDataM  <= '0;
            ALU_ResultM <= '0;
        end else begin
            RegWriteM   <= RegWriteE;
            MemWriteM   <= MemWriteE;
            ResultSrcM  <= ResultSrcE;
            RD_M        <= RD_E;
            PCPlus4M    <= PCPlus4E;
            WriteDataM  <= fwd_b;
            ALU_ResultM <= alu_result;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: vector table plus forwarding and reset sequences.
// Expectations for Funct3E-driven branches follow EXEC_BRANCH_EXT_EN.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE, Funct3E;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

    int checks   = 0;
    int failures = 0;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .Funct3E(Funct3E), .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
        .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ResultW(ResultW),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M),
        .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        reg_write, alu_src, mem_write, result_src, branch;
        logic [2:0]  alu_ctrl, funct3;
        logic [1:0]  fwd_a, fwd_b;
        logic [31:0] rd1, rd2, imm, pc;
        logic [4:0]  rd;
        logic [31:0] exp_alu, exp_wd;
        logic        exp_pcsrc;
        logic [31:0] exp_target;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rw, input logic asrc, input logic mw, input logic rs,
                                input logic br, input logic [2:0] op, input logic [2:0] f3,
                                input logic [1:0] fa, input logic [1:0] fb,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                input logic [31:0] pc, input logic [4:0] rd,
                                input logic [31:0] e_alu, input logic [31:0] e_wd,
                                input logic e_src, input logic [31:0] e_tgt);
        vec_t v;
        v.reg_write = rw; v.alu_src = asrc; v.mem_write = mw; v.result_src = rs; v.branch = br;
        v.alu_ctrl = op; v.funct3 = f3; v.fwd_a = fa; v.fwd_b = fb;
        v.rd1 = a; v.rd2 = b; v.imm = imm; v.pc = pc; v.rd = rd;
        v.exp_alu = e_alu; v.exp_wd = e_wd; v.exp_pcsrc = e_src; v.exp_target = e_tgt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        RegWriteE = v.reg_write; ALUSrcE = v.alu_src; MemWriteE = v.mem_write;
        ResultSrcE = v.result_src; BranchE = v.branch; ALUControlE = v.alu_ctrl;
        Funct3E = v.funct3; ForwardA_E = v.fwd_a; ForwardB_E = v.fwd_b;
        RD1_E = v.rd1; RD2_E = v.rd2; Imm_Ext_E = v.imm; PCE = v.pc;
        PCPlus4E = v.pc + 32'd4; RD_E = v.rd;
    endtask

    task automatic check_m_zero(input string tag);
        check({tag, " RegWriteM"},   32'(RegWriteM), 32'd0);
        check({tag, " MemWriteM"},   32'(MemWriteM), 32'd0);
        check({tag, " ResultSrcM"},  32'(ResultSrcM), 32'd0);
        check({tag, " RD_M"},        32'(RD_M), 32'd0);
        check({tag, " PCPlus4M"},    PCPlus4M, 32'd0);
        check({tag, " WriteDataM"},  WriteDataM, 32'd0);
        check({tag, " ALU_ResultM"}, ALU_ResultM, 32'd0);
    endtask

    // Drive a vector, check the combinational branch outputs, clock once, check the E/M register.
    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        drive(v);
        #1;
        check({tag, " PCSrcE"},    32'(PCSrcE), 32'(v.exp_pcsrc));
        check({tag, " PCTargetE"}, PCTargetE, v.exp_target);
        @(posedge clk); #1;
        check({tag, " ALU_ResultM"}, ALU_ResultM, v.exp_alu);
        check({tag, " WriteDataM"},  WriteDataM, v.exp_wd);
        check({tag, " RD_M"},        32'(RD_M), 32'(v.rd));
        check({tag, " RegWriteM"},   32'(RegWriteM), 32'(v.reg_write));
        check({tag, " MemWriteM"},   32'(MemWriteM), 32'(v.mem_write));
        check({tag, " ResultSrcM"},  32'(ResultSrcM), 32'(v.result_src));
        check({tag, " PCPlus4M"},    PCPlus4M, v.pc + 32'd4);
    endtask

    initial begin
        logic ext_blt, ext_bne;
`ifdef EXEC_BRANCH_EXT_EN
        ext_blt = 1'b1; ext_bne = 1'b0;
`else
        ext_blt = 1'b0; ext_bne = 1'b1;
`endif
        //        rw asrc mw rs br  op     f3     fa     fb     rd1           rd2           imm           pc            rd     exp_alu       exp_wd        src  target
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b000, 3'b000, 2'b00, 2'b00, 32'd5,        32'd7,        32'd0,        32'h0,        5'd3,  32'd12,       32'd7,        0,   32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b000, 3'b000, 2'b00, 2'b00, 32'h7FFFFFFF, 32'd1,        32'd0,        32'h40,       5'd4,  32'h80000000, 32'd1,        0,   32'h40));
        vecs.push_back(mk(1, 0, 0, 1, 0, 3'b001, 3'b000, 2'b00, 2'b00, 32'd0,        32'd1,        32'd0,        32'h44,       5'd5,  32'hFFFFFFFF, 32'd1,        0,   32'h44));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b101, 3'b000, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h48,       5'd6,  32'd1,        32'd1,        0,   32'h48));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b110, 3'b000, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h4C,       5'd7,  32'd0,        32'd1,        0,   32'h4C));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b100, 3'b000, 2'b00, 2'b00, 32'h0000F0F0, 32'h0000FFFF, 32'd0,        32'h50,       5'd8,  32'h00000F0F, 32'h0000FFFF, 0,   32'h50));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b010, 3'b000, 2'b00, 2'b00, 32'h0000F0F0, 32'h00000FF0, 32'd0,        32'h54,       5'd9,  32'h000000F0, 32'h00000FF0, 0,   32'h54));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b011, 3'b000, 2'b00, 2'b00, 32'h0000F000, 32'h0000000F, 32'd0,        32'h58,       5'd10, 32'h0000F00F, 32'h0000000F, 0,   32'h58));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b111, 3'b000, 2'b00, 2'b00, 32'd123,      32'd456,      32'd0,        32'h5C,       5'd11, 32'd0,        32'd456,      0,   32'h5C));
        // store: WriteDataM carries RD2 even though B selects the immediate
        vecs.push_back(mk(0, 1, 1, 0, 0, 3'b000, 3'b010, 2'b00, 2'b00, 32'h200,      32'hDEADBEEF, 32'd8,        32'h60,       5'd0,  32'h208,      32'hDEADBEEF, 0,   32'h68));
        vecs.push_back(mk(0, 0, 0, 0, 1, 3'b001, 3'b000, 2'b00, 2'b00, 32'd9,        32'd9,        32'h20,       32'h100,      5'd0,  32'd0,        32'd9,        1,   32'h120));
        vecs.push_back(mk(0, 0, 0, 0, 1, 3'b001, 3'b000, 2'b00, 2'b00, 32'd9,        32'd8,        32'h20,       32'h100,      5'd0,  32'd1,        32'd8,        0,   32'h120));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3'b001, 3'b000, 2'b00, 2'b00, 32'd9,        32'd9,        32'h20,       32'h100,      5'd0,  32'd0,        32'd9,        0,   32'h120));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b000, 3'b000, 2'b00, 2'b00, 32'd1,        32'd2,        32'hFFFFFFF8, 32'h4,        5'd12, 32'd3,        32'd2,        0,   32'hFFFFFFFC));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b000, 3'b000, 2'b11, 2'b11, 32'd10,       32'd20,       32'd0,        32'h70,       5'd13, 32'd30,       32'd20,       0,   32'h70));
        vecs.push_back(mk(0, 0, 0, 0, 1, 3'b001, 3'b100, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h80,       5'd0,  32'hFFFFFFFE, 32'd1,        ext_blt, 32'h80));
        vecs.push_back(mk(0, 0, 0, 0, 1, 3'b001, 3'b110, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h80,       5'd0,  32'hFFFFFFFE, 32'd1,        0,   32'h80));
        vecs.push_back(mk(0, 0, 0, 0, 1, 3'b001, 3'b001, 2'b00, 2'b00, 32'd5,        32'd5,        32'd0,        32'h80,       5'd0,  32'd0,        32'd5,        ext_bne, 32'h80));

        ResultW = 32'h0000AAAA;
        rst = 1'b0;
        drive(vecs[0]);
        #2;
        check_m_zero("por");
        @(posedge clk); #1;
        check_m_zero("por_clk");
        rst = 1'b1;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Back-to-back dependency through the E/M register and the writeback path.
        drive(mk(1, 0, 0, 0, 0, 3'b000, 3'b000, 2'b00, 2'b00, 32'h10, 32'h0, 32'h0, 32'h200, 5'd1, 0, 0, 0, 0));
        @(posedge clk); #1;
        check("dep1 ALU_ResultM", ALU_ResultM, 32'h10);
        ResultW = 32'h55;
        drive(mk(1, 1, 0, 0, 0, 3'b000, 3'b000, 2'b10, 2'b01, 32'h0, 32'h3, 32'h4, 32'h204, 5'd2, 0, 0, 0, 0));
        @(posedge clk); #1;
        check("dep2 ALU_ResultM", ALU_ResultM, 32'h14);
        check("dep2 WriteDataM", WriteDataM, 32'h55);
        drive(mk(1, 0, 0, 0, 0, 3'b000, 3'b000, 2'b10, 2'b10, 32'h1, 32'h2, 32'h0, 32'h208, 5'd3, 0, 0, 0, 0));
        @(posedge clk); #1;
        check("dep3 ALU_ResultM", ALU_ResultM, 32'h28);
        check("dep3 WriteDataM", WriteDataM, 32'h14);

        // Mid-operation reset between edges; comb outputs keep following inputs.
        rst = 1'b0;
        drive(mk(1, 0, 0, 0, 1, 3'b000, 3'b000, 2'b10, 2'b10, 32'h77, 32'h66, 32'h0, 32'h300, 5'd9, 0, 0, 0, 0));
        #1;
        check_m_zero("mid_rst");
        check("mid_rst PCTargetE", PCTargetE, 32'h300);
        check("mid_rst fwd10 reads 0", 32'(PCSrcE), 32'd1);
        @(posedge clk); #1;
        check_m_zero("mid_rst_clk");
        rst = 1'b1;
        drive(mk(1, 0, 0, 0, 0, 3'b000, 3'b000, 2'b00, 2'b00, 32'd5, 32'd7, 32'd0, 32'h0, 5'd3, 0, 0, 0, 0));
        @(posedge clk); #1;
        check("post_rst ALU_ResultM", ALU_ResultM, 32'd12);
        check("post_rst RD_M", 32'(RD_M), 32'd3);
        check("post_rst RegWriteM", 32'(RegWriteM), 32'd1);
        check("post_rst WriteDataM", WriteDataM, 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
